// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared fetch FSM encoding, queue entry layout and constants for if_prefetch
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int IF_XLEN = 32;

  localparam logic [IF_XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  // Queue entries are packed {pc, instr}; the queue stores this layout at width 2*XLEN.
  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_queue.sv
// rtl/if_queue.sv - power-of-two FIFO holding fetched {pc, instr} entries with flush
module if_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction prefetcher with redirect and drain; IF_PREFETCH_STALL_CNT_EN adds stall_cnt
module if_prefetch
  import if_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pc_reset,
  input  logic            is_jump,
  input  logic            is_branch,
  input  logic [XLEN-1:0] jump_addr,
  input  logic [XLEN-1:0] branch_addr,
  output logic            read_req,
  output logic [XLEN-1:0] read_addr,
  input  logic            read_ack,
  input  logic [XLEN-1:0] read_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next
`ifdef IF_PREFETCH_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int              CNT_W = $clog2(DEPTH) + 1;
  localparam int              EW    = 2 * XLEN;
  localparam logic [XLEN-1:0] STEP  = XLEN'(4);

  fetch_state_t     state, state_d;
  logic [XLEN-1:0]  fetch_pc, fetch_pc_d, read_addr_d;
  logic             started;
  logic             redirect;
  logic [XLEN-1:0]  target;
  logic             push, pop;
  logic [EW-1:0]    head;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  head_pc;

  assign redirect = pc_reset | is_branch | is_jump;
  assign target   = pc_reset ? RESET_PC : (is_branch ? branch_addr : jump_addr);

  // started holds off the first request one cycle after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      read_addr <= RESET_PC;
      started   <= 1'b0;
    end else begin
      state     <= state_d;
      fetch_pc  <= fetch_pc_d;
      read_addr <= read_addr_d;
      started   <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state;
    fetch_pc_d  = fetch_pc;
    read_addr_d = read_addr;
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = target;
        end else if (started && (count != CNT_W'(DEPTH))) begin
          state_d     = REQ;
          read_addr_d = fetch_pc;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = target;
          state_d    = read_ack ? IDLE : DRAIN;
        end else if (read_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc + STEP;
          state_d    = IDLE;
        end
      end
      DRAIN: begin
        // The in-flight word belongs to the abandoned stream and is dropped.
        if (redirect) fetch_pc_d = target;
        if (read_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign read_req = (state != IDLE);

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect;

  if_queue #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data ({read_addr, read_data}),
    .head_data (head),
    .count     (count)
  );

  assign head_pc     = head[EW-1:XLEN];
  assign pc          = out_valid ? head_pc : '0;
  assign instruction = out_valid ? head[XLEN-1:0] : '0;
  assign pc_next     = out_valid ? head_pc + STEP : '0;

`ifdef IF_PREFETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (pc_reset)
      stall_cnt <= '0;
    else if (out_ready && !out_valid && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - self-checking bench for if_prefetch with a queue-level reference model
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pc_reset = 1'b0, is_jump = 1'b0, is_branch = 1'b0;
  logic [31:0] jump_addr = '0, branch_addr = '0;
  logic        read_req;
  logic [31:0] read_addr;
  logic        read_ack = 1'b0;
  logic [31:0] read_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instruction, pc, pc_next;
`ifdef IF_PREFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  if_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc_reset    (pc_reset),
    .is_jump     (is_jump),
    .is_branch   (is_branch),
    .jump_addr   (jump_addr),
    .branch_addr (branch_addr),
    .read_req    (read_req),
    .read_addr   (read_addr),
    .read_ack    (read_ack),
    .read_data   (read_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instruction (instruction),
    .pc          (pc),
    .pc_next     (pc_next)
`ifdef IF_PREFETCH_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Memory responder: word = address ^ salt, acked after ack_lat waiting cycles.
  int          ack_lat = 0;
  int          wait_cnt = 0;
  logic [31:0] salt = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      read_ack = 1'b0;
      wait_cnt = 0;
    end else if (read_ack) begin
      read_ack = 1'b0;
      wait_cnt = 0;
    end else if (read_req) begin
      if (wait_cnt >= ack_lat) begin
        read_ack  = 1'b1;
        read_data = read_addr ^ salt;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Reference model: ordered list of fetched entries, next expected fetch address,
  // and whether the outstanding fetch belongs to an abandoned stream.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] exp_fetch = '0;
  logic        discard = 1'b0;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [31:0] ack_log[$];
  logic [31:0] seen_pc[$];
  logic [31:0] seen_instr[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      exp_fetch  = 32'h0;
      discard    = 1'b0;
      hold_valid = 1'b0;
    end else begin
      hold_valid = read_req && !read_ack;
      hold_addr  = read_addr;
      if (read_ack) ack_log.push_back(read_addr);
      if (pc_reset || is_branch || is_jump) begin
        discard = read_req && !read_ack;
        mq.delete();
        exp_fetch = pc_reset ? 32'h0 : (is_branch ? branch_addr : jump_addr);
      end else begin
        if (out_ready && mq.size() != 0) void'(mq.pop_front());
        if (read_ack) begin
          if (discard) begin
            discard = 1'b0;
          end else begin
            check("fetch_addr", read_addr, exp_fetch);
            mq.push_back('{exp_fetch, exp_fetch ^ salt});
            exp_fetch = exp_fetch + 32'd4;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) begin
        check("head_pc", pc, mq[0].pc);
        check("head_instr", instruction, mq[0].instr);
        check("head_pc_next", pc_next, mq[0].pc + 32'd4);
        seen_pc.push_back(pc);
        seen_instr.push_back(instruction);
      end
      if (hold_valid) begin
        check("req_hold", {31'b0, read_req}, 32'd1);
        check("addr_hold", read_addr, hold_addr);
      end
    end
  end

  task automatic clear_logs();
    ack_log.delete();
    seen_pc.delete();
    seen_instr.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_acks(input int n, input int budget);
    int k = 0;
    while (ack_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("ack_wait", {31'b0, ack_log.size() >= n}, 32'd1);
  endtask

  initial begin
    int  n8;
    bit  found;
    int  k;

    // Reset state and first-request latency; word == address.
    salt = '0; ack_lat = 0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_read_req", {31'b0, read_req}, 32'd0);
    check("rst_read_addr", read_addr, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc_next", pc_next, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
    @(negedge clk);
    check("req_edge1", {31'b0, read_req}, 32'd0);
    @(negedge clk);
    check("req_edge2", {31'b0, read_req}, 32'd1);
    repeat (10) @(negedge clk);
    wait_acks(3, 10);
    check("s1_addr0", ack_log[0], 32'h0);
    check("s1_addr1", ack_log[1], 32'h4);
    check("s1_addr2", ack_log[2], 32'h8);
    check("s1_seen", {31'b0, seen_pc.size() >= 2}, 32'd1);
    check("s1_pc0", seen_pc[0], 32'h0);
    check("s1_instr0", seen_instr[0], 32'h0);
    check("s1_pc1", seen_pc[1], 32'h4);
    check("s1_instr1", seen_instr[1], 32'h4);

    // Fill with no consumer: exactly DEPTH fetches, then idle; one pop frees one slot.
    out_ready = 1'b0;
    do_reset();
    repeat (20) @(negedge clk);
    check("s2_acks_full", ack_log.size(), 32'd4);
    repeat (5) begin
      @(negedge clk);
      check("s2_idle_full", {31'b0, read_req}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (8) @(negedge clk);
    check("s2_acks_pop", ack_log.size(), 32'd5);
    check("s2_refill_addr", ack_log[4], 32'h10);

    // Branch and jump together: branch wins, queue empties.
    branch_addr = 32'h100; jump_addr = 32'h200;
    is_branch = 1'b1; is_jump = 1'b1;
    @(negedge clk);
    is_branch = 1'b0; is_jump = 1'b0;
    check("s3_flushed", {31'b0, out_valid}, 32'd0);
    ack_log.delete();
    wait_acks(1, 20);
    check("s3_target", ack_log[0], 32'h100);

    // Redirect while the fetch of 0x8 is pending; its word must never surface.
    salt = 32'h1234_0000; ack_lat = 3; out_ready = 1'b1;
    do_reset();
    found = 1'b0;
    k = 0;
    while (!found && k < 100) begin
      @(negedge clk);
      k++;
      if (read_req && read_addr == 32'h8) found = 1'b1;
    end
    check("s4_req8_seen", {31'b0, found}, 32'd1);
    jump_addr = 32'h40; is_jump = 1'b1;
    @(negedge clk);
    is_jump = 1'b0;
    repeat (30) @(negedge clk);
    check("s4_drained_addr", ack_log[2], 32'h8);
    check("s4_next_addr", ack_log[3], 32'h40);
    n8 = 0;
    found = 1'b0;
    foreach (seen_pc[i]) begin
      if (seen_pc[i] == 32'h8) n8++;
      if (seen_pc[i] == 32'h40) found = 1'b1;
    end
    check("s4_no_pc8", n8, 32'd0);
    check("s4_pc40_out", {31'b0, found}, 32'd1);

    // Reset in the middle of a request abandons it immediately.
    salt = 32'h5a5a_0000; ack_lat = 5; out_ready = 1'b1;
    do_reset();
    k = 0;
    while (!read_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("s5_req_drop", {31'b0, read_req}, 32'd0);
    check("s5_valid_drop", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
`ifdef IF_PREFETCH_STALL_CNT_EN
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("stall_cnt_min", {31'b0, stall_cnt >= 32'd5}, 32'd1);
`endif
    wait_acks(1, 30);
    check("s5_first_addr", ack_log[0], 32'h0);

    // Address wrap across 2^32, then pc_reset restart.
    ack_lat = 0; salt = 32'h0000_00ff;
    @(negedge clk);
    jump_addr = 32'hFFFF_FFF8; is_jump = 1'b1;
    @(negedge clk);
    is_jump = 1'b0;
    clear_logs();
    repeat (10) @(negedge clk);
    check("s6_wrap0", ack_log[0], 32'hFFFF_FFF8);
    check("s6_wrap1", ack_log[1], 32'hFFFF_FFFC);
    check("s6_wrap2", ack_log[2], 32'h0);
    pc_reset = 1'b1;
    @(negedge clk);
    pc_reset = 1'b0;
    clear_logs();
    repeat (8) @(negedge clk);
    check("s6_pcrst0", ack_log[0], 32'h0);
    check("s6_pcrst1", ack_log[1], 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
